// File: rtl/dma_channel_arbiter.sv
// Round-robin front end that lets NUM_CH channel controllers share one data-mover
// read/write command path and merges the two completion statuses back to the owner.
module dma_channel_arbiter #(
   parameter int  NUM_CH = 4,
   parameter int  CMD_W  = 96,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [NUM_CH-1:0]       ChCmdValid,
   output logic [NUM_CH-1:0]       ChCmdReady,
   input  logic [NUM_CH*CMD_W-1:0] ChCmdData,
   output logic [NUM_CH-1:0]       ChStatValid,
   input  logic [NUM_CH-1:0]       ChStatReady,
   output logic [NUM_CH*2-1:0]     ChStatData,
   output logic                    RdCmdValid,
   input  logic                    RdCmdReady,
   output logic [CMD_W-1:0]        RdCmdData,
   output logic                    WrCmdValid,
   input  logic                    WrCmdReady,
   output logic [CMD_W-1:0]        WrCmdData,
   input  logic                    RdStatValid,
   output logic                    RdStatReady,
   input  logic [1:0]              RdStatData,
   input  logic                    WrStatValid,
   output logic                    WrStatReady,
   input  logic [1:0]              WrStatData,
   output logic                    Busy,
   output logic [CH_W-1:0]         GrantId,
   output logic [1:0]              dbg_state
);

   // Every port pair is ready/valid: a transfer happens on a rising edge where both are
   // high; a raised valid is held with stable payload until that transfer.

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_STAT = 2'd2, REPORT = 2'd3} state_t;

   state_t            state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant;
   logic [CMD_W-1:0]  cmd_q;
   logic              rd_issued, wr_issued;
   logic              rd_got, wr_got;
   logic [1:0]        rd_stat_q, wr_stat_q;
   logic [1:0]        merged;

   logic              pick_found;
   logic [CH_W-1:0]   pick;
   logic [CH_W:0]     scan;

   logic              rd_cmd_hs, wr_cmd_hs, rd_stat_hs, wr_stat_hs;

   // Search ptr, ptr+1, ... with wrap; the extra scan bit absorbs the overflow.
   always_comb begin
      pick_found = 1'b0;
      pick       = '0;
      scan       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan = {1'b0, rr_ptr} + (CH_W+1)'(k);
         if (scan >= (CH_W+1)'(NUM_CH))
            scan = scan - (CH_W+1)'(NUM_CH);
         if (!pick_found && ChCmdValid[scan[CH_W-1:0]]) begin
            pick_found = 1'b1;
            pick       = scan[CH_W-1:0];
         end
      end
   end

   always_comb begin
      ChCmdReady = '0;
      if (state == IDLE && pick_found)
         ChCmdReady[pick] = 1'b1;
   end

   assign RdCmdValid  = (state == ISSUE) && !rd_issued;
   assign WrCmdValid  = (state == ISSUE) && !wr_issued;
   assign RdCmdData   = cmd_q;
   assign WrCmdData   = cmd_q;
   assign RdStatReady = (state == ISSUE || state == WAIT_STAT) && !rd_got;
   assign WrStatReady = (state == ISSUE || state == WAIT_STAT) && !wr_got;

   assign rd_cmd_hs  = RdCmdValid && RdCmdReady;
   assign wr_cmd_hs  = WrCmdValid && WrCmdReady;
   assign rd_stat_hs = RdStatValid && RdStatReady;
   assign wr_stat_hs = WrStatValid && WrStatReady;

   // A read error dominates whatever the write side reported.
   assign merged = (rd_stat_q != 2'b00) ? rd_stat_q : wr_stat_q;

   always_comb begin
      ChStatValid = '0;
      ChStatData  = '0;
      if (state == REPORT) begin
         ChStatValid[grant]              = 1'b1;
         ChStatData[int'(grant)*2 +: 2]  = merged;
      end
   end

   assign Busy      = (state != IDLE);
   assign GrantId   = grant;
   assign dbg_state = state;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         grant     <= '0;
         cmd_q     <= '0;
         rd_issued <= 1'b0;
         wr_issued <= 1'b0;
         rd_got    <= 1'b0;
         wr_got    <= 1'b0;
         rd_stat_q <= '0;
         wr_stat_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  cmd_q <= ChCmdData[int'(pick)*CMD_W +: CMD_W];
                  grant <= pick;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (rd_cmd_hs) rd_issued <= 1'b1;
               if (wr_cmd_hs) wr_issued <= 1'b1;
               if (rd_issued && wr_issued) state <= WAIT_STAT;
            end
            WAIT_STAT: begin
               if ((rd_got || rd_stat_hs) && (wr_got || wr_stat_hs))
                  state <= REPORT;
            end
            REPORT: begin
               if (ChStatReady[grant]) begin
                  rr_ptr    <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + CH_W'(1);
                  rd_issued <= 1'b0;
                  wr_issued <= 1'b0;
                  rd_got    <= 1'b0;
                  wr_got    <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Status may land any time in ISSUE/WAIT_STAT, even before its own command issues.
         if (rd_stat_hs) begin
            rd_stat_q <= RdStatData;
            rd_got    <= 1'b1;
         end
         if (wr_stat_hs) begin
            wr_stat_q <= WrStatData;
            wr_got    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: a data-mover model plus expected queues for
// grants, issued commands and per-channel reports, checked by a negedge monitor.
module tb_dma_channel_arbiter;

   localparam int NUM_CH = 4;
   localparam int CMD_W  = 96;
   localparam int CH_W   = 2;

   logic                    ACLK = 1'b0;
   logic                    ARESETn = 1'b0;
   logic [NUM_CH-1:0]       ChCmdValid = '0;
   logic [NUM_CH-1:0]       ChCmdReady;
   logic [NUM_CH*CMD_W-1:0] ChCmdData = '0;
   logic [NUM_CH-1:0]       ChStatValid;
   logic [NUM_CH-1:0]       ChStatReady = '1;
   logic [NUM_CH*2-1:0]     ChStatData;
   logic                    RdCmdValid;
   logic                    RdCmdReady = 1'b1;
   logic [CMD_W-1:0]        RdCmdData;
   logic                    WrCmdValid;
   logic                    WrCmdReady = 1'b1;
   logic [CMD_W-1:0]        WrCmdData;
   logic                    RdStatValid = 1'b0;
   logic                    RdStatReady;
   logic [1:0]              RdStatData = '0;
   logic                    WrStatValid = 1'b0;
   logic                    WrStatReady;
   logic [1:0]              WrStatData = '0;
   logic                    Busy;
   logic [CH_W-1:0]         GrantId;
   logic [1:0]              dbg_state;

   dma_channel_arbiter #(.NUM_CH(NUM_CH), .CMD_W(CMD_W)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ChCmdValid(ChCmdValid), .ChCmdReady(ChCmdReady), .ChCmdData(ChCmdData),
      .ChStatValid(ChStatValid), .ChStatReady(ChStatReady), .ChStatData(ChStatData),
      .RdCmdValid(RdCmdValid), .RdCmdReady(RdCmdReady), .RdCmdData(RdCmdData),
      .WrCmdValid(WrCmdValid), .WrCmdReady(WrCmdReady), .WrCmdData(WrCmdData),
      .RdStatValid(RdStatValid), .RdStatReady(RdStatReady), .RdStatData(RdStatData),
      .WrStatValid(WrStatValid), .WrStatReady(WrStatReady), .WrStatData(WrStatData),
      .Busy(Busy), .GrantId(GrantId), .dbg_state(dbg_state)
   );

   // clock/reset
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int tests = 0;
   int failed = 0;

   logic [CH_W-1:0]  exp_grant_q[$];
   logic [CMD_W-1:0] exp_rd_q[$];
   logic [CMD_W-1:0] exp_wr_q[$];
   logic [CH_W+1:0]  exp_rep_q[$];

   // data mover model controls
   int         rd_delay = 0, wr_delay = 0, wr_hold = 0;
   logic [1:0] rd_val = 2'b00, wr_val = 2'b00;
   logic       rd_pend = 0, wr_pend = 0, rd_drop = 0, wr_drop = 0;
   int         rd_cnt = 0, wr_cnt = 0;

   // monitor bookkeeping
   int cyc = 0, grant_cnt = 0, rep_cnt = 0;
   int accept_cyc = 0, stat_rise_cyc = 0, rep_hs_cyc = 0;
   int rd_vcnt = 0, wr_vcnt = 0, wr_bad = 0;
   logic [CMD_W-1:0] wr_ref = '0;
   logic prev_stat_any = 1'b0;
   logic [CH_W+1:0]   rep_e;
   logic [CH_W-1:0]   grant_e;
   logic [CMD_W-1:0]  cmd_e;
   logic [NUM_CH*2-1:0] ev_data;
   logic [NUM_CH-1:0]   ev_vld;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Mover model first, then monitors, in one negedge process so readies are settled.
   initial begin
      forever begin
         @(negedge ACLK);
         cyc++;
         if (!ARESETn) begin
            RdStatValid = 0; WrStatValid = 0; rd_pend = 0; wr_pend = 0;
            rd_drop = 0; wr_drop = 0; wr_hold = 0; RdCmdReady = 1; WrCmdReady = 1;
            prev_stat_any = 0;
         end else begin
            if (rd_drop) begin RdStatValid = 0; rd_drop = 0; end
            if (wr_drop) begin WrStatValid = 0; wr_drop = 0; end
            if (rd_pend) begin
               if (rd_cnt == 0) begin RdStatValid = 1; RdStatData = rd_val; rd_pend = 0; end
               else rd_cnt--;
            end
            if (wr_pend) begin
               if (wr_cnt == 0) begin WrStatValid = 1; WrStatData = wr_val; wr_pend = 0; end
               else wr_cnt--;
            end
            RdCmdReady = 1;
            if (WrCmdValid && wr_hold > 0) begin WrCmdReady = 0; wr_hold--; end
            else WrCmdReady = 1;
            if (RdCmdValid && RdCmdReady) begin rd_pend = 1; rd_cnt = rd_delay; end
            if (WrCmdValid && WrCmdReady) begin wr_pend = 1; wr_cnt = wr_delay; end
            if (RdStatValid && RdStatReady) rd_drop = 1;
            if (WrStatValid && WrStatReady) wr_drop = 1;

            if (RdCmdValid) rd_vcnt++;
            if (WrCmdValid) begin
               wr_vcnt++;
               if (WrCmdData !== wr_ref) wr_bad++;
            end
            if (RdCmdValid && RdCmdReady) begin
               cmd_e = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 'x;
               check("rd_cmd_data", 128'(RdCmdData), 128'(cmd_e));
            end
            if (WrCmdValid && WrCmdReady) begin
               cmd_e = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 'x;
               check("wr_cmd_data", 128'(WrCmdData), 128'(cmd_e));
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (ChCmdValid[i] && ChCmdReady[i]) begin
                  grant_cnt++;
                  accept_cyc = cyc;
                  grant_e = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 'x;
                  check("grant_order", 128'(i), 128'(grant_e));
               end
            end
            for (int i = 0; i < NUM_CH; i++) begin
               if (ChStatValid[i] && ChStatReady[i]) begin
                  rep_cnt++;
                  rep_hs_cyc = cyc;
                  rep_e = (exp_rep_q.size() > 0) ? exp_rep_q.pop_front() : 'x;
                  ev_data = '0;
                  ev_vld  = '0;
                  ev_data[int'(rep_e[CH_W+1:2])*2 +: 2] = rep_e[1:0];
                  ev_vld[rep_e[CH_W+1:2]] = 1'b1;
                  check("report", {ChStatValid, ChStatData, GrantId},
                        {ev_vld, ev_data, rep_e[CH_W+1:2]});
               end
            end
            if ((|ChStatValid) && !prev_stat_any) stat_rise_cyc = cyc;
            prev_stat_any = |ChStatValid;
         end
      end
   end

   // driver tasks
   task automatic expect_cmd(input int ch, input logic [CMD_W-1:0] data, input logic [1:0] stat);
      ChCmdData[ch*CMD_W +: CMD_W] = data;
      exp_grant_q.push_back(CH_W'(ch));
      exp_rd_q.push_back(data);
      exp_wr_q.push_back(data);
      exp_rep_q.push_back({CH_W'(ch), stat});
   endtask

   task automatic wait_grant(input int g0);
      for (int n = 0; n < 100; n++) begin
         @(posedge ACLK); #1;
         if (grant_cnt != g0) break;
      end
      check("grant_wait", 128'(grant_cnt != g0), 128'(1));
   endtask

   task automatic issue_cmd(input int ch, input logic [CMD_W-1:0] data, input logic [1:0] stat);
      int g0;
      expect_cmd(ch, data, stat);
      @(posedge ACLK); #1;
      g0 = grant_cnt;
      ChCmdValid[ch] = 1'b1;
      wait_grant(g0);
      ChCmdValid[ch] = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int n = 0; n < 400; n++) begin
         @(posedge ACLK); #1;
         if (exp_rep_q.size() == 0 && !Busy) break;
      end
      check(name, 128'(exp_rep_q.size() == 0 && !Busy), 128'(1));
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {Busy, ChCmdReady, ChStatValid, RdCmdValid, WrCmdValid,
                   RdStatReady, WrStatReady, GrantId}, 128'(0));
   endtask

   initial begin
      int g0, bad, seen;
      repeat (3) @(posedge ACLK);
      #1 ARESETn = 1'b1;
      @(negedge ACLK);
      check_reset_outputs("reset_state");

      // All four channels request continuously: 0,1,2,3,0,1.
      for (int k = 0; k < 6; k++) expect_cmd(k % 4, {24{4'(k % 4)}}, 2'b00);
      @(posedge ACLK); #1;
      g0 = grant_cnt;
      ChCmdValid = 4'hF;
      for (int n = 0; n < 200; n++) begin
         @(posedge ACLK); #1;
         if (grant_cnt >= g0 + 6) break;
      end
      ChCmdValid = '0;
      check("rr_grant_count", 128'(grant_cnt - g0), 128'(6));
      wait_done("rr_done");

      // Single channel 2, zero-latency mover.
      issue_cmd(2, {12{8'hA5}}, 2'b00);
      seen = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge ACLK);
         if (ChStatValid[2] && ChStatReady[2]) begin seen = 1; break; end
      end
      check("ch2_report_seen", 128'(seen), 128'(1));
      // accept is sampled the half-cycle before its edge
      check("ch2_latency", 128'(stat_rise_cyc - accept_cyc - 1), 128'(3));
      @(negedge ACLK);
      check("busy_after_report", 128'(Busy), 128'(0));
      wait_done("ch2_done");

      // Write command back-pressured 5 cycles; write status returns before read status.
      rd_vcnt = 0; wr_vcnt = 0; wr_bad = 0;
      wr_ref = 96'h0123_4567_89AB_CDEF_0F1E_2D3C;
      wr_hold = 5; rd_delay = 8; wr_delay = 0;
      g0 = rep_cnt;
      issue_cmd(0, wr_ref, 2'b00);
      wait_done("wr_hold_done");
      check("rd_valid_cycles", 128'(rd_vcnt), 128'(1));
      check("wr_valid_cycles", 128'(wr_vcnt), 128'(6));
      check("wr_data_stable", 128'(wr_bad), 128'(0));
      check("single_report", 128'(rep_cnt - g0), 128'(1));
      rd_delay = 0;

      // Merge rule.
      rd_val = 2'b10; wr_val = 2'b01;
      issue_cmd(1, {24{4'h7}}, 2'b10);
      wait_done("merge_a_done");
      rd_val = 2'b00; wr_val = 2'b11;
      issue_cmd(3, {24{4'hC}}, 2'b11);
      wait_done("merge_b_done");
      rd_val = 2'b00; wr_val = 2'b00;

      // Report held 10 cycles while ch1 requests.
      ChStatReady[0] = 1'b0;
      issue_cmd(0, {24{4'h3}}, 2'b00);
      for (int n = 0; n < 50; n++) begin
         @(posedge ACLK); #1;
         if (ChStatValid[0]) break;
      end
      check("hold_report_valid", 128'(ChStatValid[0]), 128'(1));
      expect_cmd(1, {24{4'h9}}, 2'b00);
      ChCmdValid[1] = 1'b1;
      bad = 0;
      for (int n = 0; n < 10; n++) begin
         @(posedge ACLK); #1;
         if (ChCmdReady[1]) bad++;
      end
      check("no_grant_during_report", 128'(bad), 128'(0));
      g0 = grant_cnt;
      ChStatReady = '1;
      wait_grant(g0);
      ChCmdValid[1] = 1'b0;
      check("grant_after_report", 128'(accept_cyc), 128'(rep_hs_cyc + 1));
      wait_done("hold_done");

      // Reset during WAIT_STAT, then ch1 and ch3 request together.
      rd_delay = 30;
      issue_cmd(2, {24{4'hE}}, 2'b00);
      for (int n = 0; n < 50; n++) begin
         @(posedge ACLK); #1;
         if (dbg_state == 2'd2) break;
      end
      check("reached_wait_stat", 128'(dbg_state), 128'(2));
      ARESETn = 1'b0;
      exp_rep_q.delete();
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      rd_delay = 0;
      @(negedge ACLK);
      check_reset_outputs("mid_reset_state");
      expect_cmd(1, {24{4'h1}}, 2'b00);
      expect_cmd(3, {24{4'h5}}, 2'b00);
      @(posedge ACLK); #1;
      g0 = grant_cnt;
      ChCmdValid[1] = 1'b1;
      ChCmdValid[3] = 1'b1;
      wait_grant(g0);
      ChCmdValid[1] = 1'b0;
      wait_grant(g0 + 1);
      ChCmdValid[3] = 1'b0;
      wait_done("post_reset_done");

      check("queues_empty", 128'(exp_grant_q.size() + exp_rd_q.size() +
                                 exp_wr_q.size() + exp_rep_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
